// File: rtl/add_seq_if.sv
// add_seq_if: operand/result bundle for the chunked adder/subtractor.
//   master: drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf
//   slave : the add_seq datapath side of the same signals
interface add_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/add_seq.sv
// add_seq: multi-cycle adder/subtractor that processes CHUNK bits per clock.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : add_seq_if slave -- start/sub/a/b/cin in, busy/done/sum/cout/ovf out
// Subtraction is a + ~b + 1, so cout=1 means "no borrow" in sub mode.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one CHUNK-wide slice of a + b' + carry per cycle, low slice first
// DONE  | result valid, done pulses for this one cycle
module add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic     clk,
  input logic     reset,
  add_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic             busy_r;
  logic             done_r;
  logic             cout_r;
  logic             ovf_r;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;

  always_comb begin
    a_chunk   = a_r[int'(idx)*CHUNK +: CHUNK];
    b_chunk   = b_r[int'(idx)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_r[int'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry <= chunk_sum[CHUNK];
          if (idx == LAST_IDX) begin
            // Last slice: its MSB is the result sign bit, so overflow and
            // carry-out are resolved here together with the final write.
            idx    <= '0;
            cout_r <= chunk_sum[CHUNK];
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                      (chunk_sum[CHUNK-1] != a_r[WIDTH-1]);
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_add_seq.sv
module tb_add_seq;
  logic        clk;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;

  int total = 0;
  int bad   = 0;

  // Three configurations driven in lockstep: CHUNK = 8, 32, 1.
  add_seq_if #(.WIDTH(32)) bus8 ();
  add_seq_if #(.WIDTH(32)) bus32 ();
  add_seq_if #(.WIDTH(32)) bus1 ();

  assign bus8.start = start;  assign bus8.sub = sub;  assign bus8.a = a;
  assign bus8.b = b;          assign bus8.cin = cin;
  assign bus32.start = start; assign bus32.sub = sub; assign bus32.a = a;
  assign bus32.b = b;         assign bus32.cin = cin;
  assign bus1.start = start;  assign bus1.sub = sub;  assign bus1.a = a;
  assign bus1.b = b;          assign bus1.cin = cin;

  add_seq #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
  add_seq #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  add_seq #(.WIDTH(32), .CHUNK(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));

  logic        busy_v [3];
  logic        done_v [3];
  logic [31:0] sum_v  [3];
  logic        cout_v [3];
  logic        ovf_v  [3];
  assign busy_v[0] = bus8.busy;  assign busy_v[1] = bus32.busy; assign busy_v[2] = bus1.busy;
  assign done_v[0] = bus8.done;  assign done_v[1] = bus32.done; assign done_v[2] = bus1.done;
  assign sum_v[0]  = bus8.sum;   assign sum_v[1]  = bus32.sum;  assign sum_v[2]  = bus1.sum;
  assign cout_v[0] = bus8.cout;  assign cout_v[1] = bus32.cout; assign cout_v[2] = bus1.cout;
  assign ovf_v[0]  = bus8.ovf;   assign ovf_v[1]  = bus32.ovf;  assign ovf_v[2]  = bus1.ovf;

  int nch [3] = '{4, 1, 32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic on 64-bit integers.
  task automatic model(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic c, output logic [31:0] r, output logic co,
                       output logic ov);
    longint ux, uy, sx, sy, t, st;
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      t  = ux + uy + longint'(c);
      st = sx + sy + longint'(c);
      co = (t >= 64'sh1_0000_0000);
    end else begin
      t  = ux - uy;
      st = sx - sy;
      co = (ux >= uy);
    end
    r  = t[31:0];
    ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
  endtask

  // Issue one operation on all three DUTs and check each against the model.
  // poke: re-pulse start with fresh operands while the units are busy.
  task automatic run_op(input string tag, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input logic c, input bit poke);
    logic [31:0] er;
    logic        eco, eov;
    int          lat [3];
    int          pulses [3];
    int          bcnt [3];
    logic [31:0] gs [3];
    logic        gc [3];
    logic        go [3];
    model(s, x, y, c, er, eco, eov);
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; pulses[i] = 0; bcnt[i] = 0; gs[i] = '0; gc[i] = 1'b0; go[i] = 1'b0;
    end
    @(negedge clk);
    sub = s; a = x; b = y; cin = c; start = 1'b1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      end
      if (poke && cyc == 2) start = 1'b1;
      if (poke && cyc == 3) start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i]) bcnt[i]++;
        if (done_v[i]) begin
          pulses[i]++;
          if (pulses[i] == 1) begin
            lat[i] = cyc; gs[i] = sum_v[i]; gc[i] = cout_v[i]; go[i] = ovf_v[i];
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s[%0d] done_pulses", tag, i), 64'(pulses[i]), 64'd1);
      check($sformatf("%s[%0d] latency", tag, i), 64'(lat[i]), 64'(nch[i] + 1));
      check($sformatf("%s[%0d] busy_cycles", tag, i), 64'(bcnt[i]), 64'(nch[i] + 1));
      check($sformatf("%s[%0d] sum", tag, i), 64'(gs[i]), 64'(er));
      check($sformatf("%s[%0d] cout", tag, i), 64'(gc[i]), 64'(eco));
      check($sformatf("%s[%0d] ovf", tag, i), 64'(go[i]), 64'(eov));
      check($sformatf("%s[%0d] sum_hold", tag, i), 64'(sum_v[i]), 64'(er));
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s[%0d] busy", tag, i), 64'(busy_v[i]), 64'd0);
      check($sformatf("%s[%0d] done", tag, i), 64'(done_v[i]), 64'd0);
      check($sformatf("%s[%0d] sum", tag, i), 64'(sum_v[i]), 64'd0);
      check($sformatf("%s[%0d] cout", tag, i), 64'(cout_v[i]), 64'd0);
      check($sformatf("%s[%0d] ovf", tag, i), 64'(ovf_v[i]), 64'd0);
    end
  endtask

  task automatic watch_no_done(input string tag, input int ncyc);
    int seen;
    seen = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (done_v[i] || busy_v[i]) seen++;
    end
    check($sformatf("%s activity", tag), 64'(seen), 64'd0);
  endtask

  logic [31:0] corner [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run_op("sweep", 1'b0, 32'(x), 32'(y), 1'(c), 1'b0);

    run_op("all_ones", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("sub_5_7", 1'b1, 32'd5, 32'd7, 1'b0, 1'b0);
    run_op("sub_7_5", 1'b1, 32'd7, 32'd5, 1'b1, 1'b0);
    run_op("sub_min_1", 1'b1, 32'h80000000, 32'd1, 1'b0, 1'b0);
    run_op("add_max_max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_op("poke_busy", 1'b0, 32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b1);

    for (int n = 0; n < 150; n++)
      run_op("rand", 1'($urandom), pick(), pick(), 1'($urandom), 1'(n % 5 == 0));

    // Abort in the second RUN cycle.
    @(negedge clk);
    sub = 1'b0; a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check_cleared("abort");
    watch_no_done("abort_after", 40);

    // start together with reset is dropped.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 32'h5; b = 32'h6;
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    check_cleared("start_in_reset");
    watch_no_done("start_in_reset_after", 40);

    run_op("after_reset", 1'b1, 32'h00000010, 32'h00000020, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
